invader_grid: RTL and testbench

- Parametrised multi-row successor of the single-row invader formation block.
- Holds a ROWS x COLS alive-bitmap formation and marches it left/right, stepping down one screen row at each edge.
- Resolves player-bullet hits against any formation row; speeds up as invaders die; reports landed and cleared conditions.
- Sits between the bullet logic and the VGA renderer, which reads o_invaders_array and o_invaders_row.

---
 rtl/invader_grid.sv | 211 +++++++++++++++++++++
 tb/tb_invader_grid.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/invader_grid.sv
// invader_grid
//   Multi-row invader formation. Holds a ROWS x COLS alive bitmap, marches it
//   left/right and drops it one screen row at each edge. Player bullets are
//   resolved against every formation row. The march speeds up as invaders
//   die. The block reports landed and cleared conditions.
//
//   Optional feature: define INVADER_GRID_SCORE_EN to add o_score. o_score
//   is a saturating 16-bit score. A hit in row r adds (ROWS - r)*10.
//
// Ports
//   i_clk_25MHz       system clock
//   i_reset_n         asynchronous active-low reset
//   i_start           one-cycle pulse: reload the wave and begin marching
//   i_bullet_valid    bullet coordinates valid this cycle
//   i_bullet_x/_y     bullet column / screen row
//   o_hit             one-cycle pulse on a kill
//   o_hit_row/_col    formation row / column of the last kill
//   o_invaders_array  alive bitmap; row r is bits [r*COLS +: COLS]
//   o_invaders_row    formation row 0 sits on screen row o_invaders_row+1
//   o_alive_count     live invaders
//   o_landed          level: formation reached LAND_ROW
//   o_cleared         level: every invader destroyed
//   o_score           (INVADER_GRID_SCORE_EN only) accumulated score
//
// Bullet handshake: the bullet is sampled on every clock where i_bullet_valid
// is high. No ready/back-pressure exists. A sampled bullet that hits is
// reflected on o_hit one clock later.
module invader_grid #(
  parameter int COLS        = 20,
  parameter int ROWS        = 3,
  parameter int X_W         = 5,
  parameter int Y_W         = 4,
  parameter int INIT_WIDTH  = 9,
  parameter int LAND_ROW    = 14,
  parameter int MIN_PERIOD  = 250000,
  parameter int PERIOD_STEP = 50000
) (
  input  logic                             i_clk_25MHz,
  input  logic                             i_reset_n,
  input  logic                             i_start,
  input  logic                             i_bullet_valid,
  input  logic [X_W-1:0]                   i_bullet_x,
  input  logic [Y_W-1:0]                   i_bullet_y,
  output logic                             o_hit,
  output logic [$clog2(ROWS)-1:0]          o_hit_row,
  output logic [X_W-1:0]                   o_hit_col,
  output logic [ROWS*COLS-1:0]             o_invaders_array,
  output logic [Y_W-1:0]                   o_invaders_row,
  output logic [$clog2(ROWS*COLS+1)-1:0]   o_alive_count,
  output logic                             o_landed,
  output logic                             o_cleared
`ifdef INVADER_GRID_SCORE_EN
  ,
  output logic [15:0]                      o_score
`endif
);

  localparam int AW  = $clog2(ROWS*COLS+1);
  localparam int HRW = $clog2(ROWS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MARCH   = 2'd1;
  localparam logic [1:0] S_LANDED  = 2'd2;
  localparam logic [1:0] S_CLEARED = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  logic [1:0]           r_state;
  logic [ROWS*COLS-1:0] r_map;
  logic [Y_W-1:0]       r_row;
  logic                 r_dir;
  logic [31:0]          r_cnt;
  logic                 r_hit;
  logic [HRW-1:0]       r_hit_row;
  logic [X_W-1:0]       r_hit_col;
  logic [AW-1:0]        r_alive;

  logic [Y_W:0]         w_rel;
  logic                 w_hit;
  logic [HRW-1:0]       w_hit_row;
  logic [ROWS*COLS-1:0] w_hit_mask;
  logic [ROWS*COLS-1:0] w_init;
  logic [ROWS*COLS-1:0] w_shl;
  logic [ROWS*COLS-1:0] w_shr;
  logic                 w_edge_hi;
  logic                 w_edge_lo;
  logic [31:0]          w_thresh;
  logic                 w_due;
  logic [Y_W-1:0]       w_row_next;

  // Relative formation row of the bullet. The extra MSB flags a bullet
  // above the formation, where the subtraction underflows.
  assign w_rel = {1'b0, i_bullet_y} - {1'b0, r_row} - {{Y_W{1'b0}}, 1'b1};

  always_comb begin
    w_hit      = 1'b0;
    w_hit_row  = '0;
    w_hit_mask = '0;
    if (r_state == S_MARCH && i_bullet_valid && !w_rel[Y_W]) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (w_rel[Y_W-1:0] == Y_W'(r) && i_bullet_x == X_W'(c) && r_map[r*COLS+c]) begin
            w_hit              = 1'b1;
            w_hit_row          = HRW'(r);
            w_hit_mask[r*COLS+c] = 1'b1;
          end
        end
      end
    end
  end

  // Shifts stay inside each row; nothing crosses a row boundary.
  always_comb begin
    w_init    = '0;
    w_shl     = '0;
    w_shr     = '0;
    w_edge_hi = 1'b0;
    w_edge_lo = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < INIT_WIDTH; c++) w_init[r*COLS+c] = 1'b1;
      w_shl[r*COLS +: COLS] = r_map[r*COLS +: COLS] << 1;
      w_shr[r*COLS +: COLS] = r_map[r*COLS +: COLS] >> 1;
      w_edge_hi = w_edge_hi | r_map[r*COLS+COLS-1];
      w_edge_lo = w_edge_lo | r_map[r*COLS];
    end
  end

  assign w_thresh   = 32'(MIN_PERIOD) + 32'(r_alive) * 32'(PERIOD_STEP) - 32'd1;
  assign w_due      = (r_cnt >= w_thresh);
  assign w_row_next = r_row + Y_W'(1);

  always_ff @(posedge i_clk_25MHz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_map     <= '0;
      r_row     <= '0;
      r_dir     <= DIR_LEFT;
      r_cnt     <= '0;
      r_hit     <= 1'b0;
      r_hit_row <= '0;
      r_hit_col <= '0;
      r_alive   <= '0;
    end else begin
      r_hit <= 1'b0;
      if (i_start) begin
        r_state <= S_MARCH;
        r_map   <= w_init;
        r_row   <= '0;
        r_dir   <= DIR_LEFT;
        r_cnt   <= '0;
        r_alive <= AW'(ROWS*INIT_WIDTH);
      end else if (r_state == S_MARCH) begin
        if (w_hit) begin
          // A kill takes this cycle. A due step waits: the counter holds,
          // so the step fires next cycle.
          r_map     <= r_map & ~w_hit_mask;
          r_hit     <= 1'b1;
          r_hit_row <= w_hit_row;
          r_hit_col <= i_bullet_x;
          r_alive   <= r_alive - AW'(1);
          if (!w_due) r_cnt <= r_cnt + 32'd1;
          if (r_alive == AW'(1)) r_state <= S_CLEARED;
        end else if (w_due) begin
          r_cnt <= '0;
          if ((r_dir == DIR_LEFT && w_edge_hi) || (r_dir == DIR_RIGHT && w_edge_lo)) begin
            r_row <= w_row_next;
            r_dir <= ~r_dir;
            if (w_row_next == Y_W'(LAND_ROW)) r_state <= S_LANDED;
          end else if (r_dir == DIR_LEFT) begin
            r_map <= w_shl;
          end else begin
            r_map <= w_shr;
          end
        end else begin
          r_cnt <= r_cnt + 32'd1;
        end
      end
    end
  end

  assign o_hit            = r_hit;
  assign o_hit_row        = r_hit_row;
  assign o_hit_col        = r_hit_col;
  assign o_invaders_array = r_map;
  assign o_invaders_row   = r_row;
  assign o_alive_count    = r_alive;
  assign o_landed         = (r_state == S_LANDED);
  assign o_cleared        = (r_state == S_CLEARED);

`ifdef INVADER_GRID_SCORE_EN
  logic [15:0] r_score;
  logic [16:0] w_sum;

  // Top formation row (row 0) is worth the most.
  assign w_sum = {1'b0, r_score} + 17'((ROWS - int'(w_hit_row)) * 10);

  always_ff @(posedge i_clk_25MHz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_score <= '0;
    end else if (i_start) begin
      r_score <= '0;
    end else if (w_hit) begin
      r_score <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

  assign o_score = r_score;
`endif

endmodule

// File: tb/tb_invader_grid.sv
// Testbench for invader_grid. Runs with short step periods so that full
// marches fit in a small cycle budget. The formation geometry keeps its
// default values.
module tb_invader_grid;

  localparam int COLS = 20;
  localparam int ROWS = 3;
  localparam int MINP = 20;
  localparam int PSTEP = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        bvalid;
  logic [4:0]  bx;
  logic [3:0]  by;
  logic        hit;
  logic [1:0]  hit_row;
  logic [4:0]  hit_col;
  logic [59:0] inv_array;
  logic [3:0]  inv_row;
  logic [5:0]  alive;
  logic        landed;
  logic        cleared;
`ifdef INVADER_GRID_SCORE_EN
  logic [15:0] score;
`endif

  invader_grid #(
    .COLS(COLS), .ROWS(ROWS), .X_W(5), .Y_W(4), .INIT_WIDTH(9),
    .LAND_ROW(14), .MIN_PERIOD(MINP), .PERIOD_STEP(PSTEP)
  ) dut (
    .i_clk_25MHz(clk), .i_reset_n(rst_n), .i_start(start),
    .i_bullet_valid(bvalid), .i_bullet_x(bx), .i_bullet_y(by),
    .o_hit(hit), .o_hit_row(hit_row), .o_hit_col(hit_col),
    .o_invaders_array(inv_array), .o_invaders_row(inv_row),
    .o_alive_count(alive), .o_landed(landed), .o_cleared(cleared)
`ifdef INVADER_GRID_SCORE_EN
    , .o_score(score)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #20 clk = ~clk;

  int n_cmp;
  int n_fail;

  // expected formation model
  logic [59:0] exp_map;
  logic [3:0]  exp_row;
  logic        exp_dir;
  localparam logic [59:0] FULL_MAP = {20'h001FF, 20'h001FF, 20'h001FF};

  typedef struct {
    logic       valid;
    logic [4:0] x;
    logic [3:0] y;
    logic       exp_hit;
    logic [1:0] exp_hrow;
    logic [4:0] exp_hcol;
    logic [5:0] exp_alive;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic edge_seen;
    edge_seen = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (exp_dir == 1'b0 && exp_map[r*COLS+COLS-1]) edge_seen = 1'b1;
      if (exp_dir == 1'b1 && exp_map[r*COLS]) edge_seen = 1'b1;
    end
    if (edge_seen) begin
      exp_row = exp_row + 4'd1;
      exp_dir = ~exp_dir;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (exp_dir == 1'b0) exp_map[r*COLS +: COLS] = exp_map[r*COLS +: COLS] << 1;
        else                 exp_map[r*COLS +: COLS] = exp_map[r*COLS +: COLS] >> 1;
      end
    end
  endtask

  // Counts clocks until the bitmap or the row output changes.
  task automatic wait_change(output int cycles);
    logic [59:0] pm;
    logic [3:0]  pr;
    pm = inv_array;
    pr = inv_row;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (inv_array == pm && inv_row == pr && cycles < 2000);
    if (cycles >= 2000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL step_timeout: no step after %0d clocks", cycles);
    end
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    exp_map = FULL_MAP;
    exp_row = 4'd0;
    exp_dir = 1'b0;
  endtask

  task automatic shoot(input logic [4:0] x, input logic [3:0] y);
    @(negedge clk); bvalid = 1'b1; bx = x; by = y;
  endtask

  initial begin
    int cyc;
    int col0;
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; bvalid = 1'b0; bx = '0; by = '0;
    exp_map = '0; exp_row = '0; exp_dir = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_array", inv_array, 60'h0);
    chk("rst_alive", alive, 6'd0);
    chk("rst_flags", {hit, landed, cleared, inv_row, hit_row, hit_col}, '0);
    rst_n = 1'b1;

    // reset asserted mid-march clears everything at once
    do_start();
    chk("start_alive", alive, 6'd27);
    chk("start_array", inv_array, FULL_MAP);
    chk("start_row", inv_row, 4'd0);
    repeat (10) @(negedge clk);
    shoot(5'd2, 4'd1);
    @(negedge clk); bvalid = 1'b0;
    chk("pre_rst_hit", hit, 1'b1);
    #5 rst_n = 1'b0;
    #1;
    chk("async_rst_array", inv_array, 60'h0);
    chk("async_rst_outs", {hit, hit_row, hit_col, inv_row, alive, landed, cleared}, '0);
    @(negedge clk); rst_n = 1'b1;

    // hit table
    tv[0] = '{1'b1, 5'd3,  4'd2, 1'b1, 2'd1, 5'd3, 6'd26};
    tv[1] = '{1'b1, 5'd3,  4'd2, 1'b0, 2'd1, 5'd3, 6'd26};
    tv[2] = '{1'b1, 5'd0,  4'd1, 1'b1, 2'd0, 5'd0, 6'd25};
    tv[3] = '{1'b1, 5'd8,  4'd3, 1'b1, 2'd2, 5'd8, 6'd24};
    tv[4] = '{1'b1, 5'd9,  4'd3, 1'b0, 2'd2, 5'd8, 6'd24};
    tv[5] = '{1'b1, 5'd3,  4'd4, 1'b0, 2'd2, 5'd8, 6'd24};
    tv[6] = '{1'b1, 5'd3,  4'd0, 1'b0, 2'd2, 5'd8, 6'd24};
    tv[7] = '{1'b1, 5'd25, 4'd1, 1'b0, 2'd2, 5'd8, 6'd24};
    tv[8] = '{1'b0, 5'd5,  4'd1, 1'b0, 2'd2, 5'd8, 6'd24};
    tv[9] = '{1'b1, 5'd5,  4'd1, 1'b1, 2'd0, 5'd5, 6'd23};
    do_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); bvalid = tv[i].valid; bx = tv[i].x; by = tv[i].y;
      @(negedge clk); bvalid = 1'b0;
      if (tv[i].exp_hit) exp_map[int'(tv[i].exp_hrow)*COLS + int'(tv[i].exp_hcol)] = 1'b0;
      chk($sformatf("tv%0d_hit", i), hit, tv[i].exp_hit);
      chk($sformatf("tv%0d_hrow", i), hit_row, tv[i].exp_hrow);
      chk($sformatf("tv%0d_hcol", i), hit_col, tv[i].exp_hcol);
      chk($sformatf("tv%0d_alive", i), alive, tv[i].exp_alive);
      chk($sformatf("tv%0d_array", i), inv_array, exp_map);
    end
`ifdef INVADER_GRID_SCORE_EN
    chk("score_table", score, 16'd90);
`endif

    // hit on the cycle a step is due: kill first, step one clock later
    do_start();
    wait_change(cyc);
    model_step();
    chk("col_first_gap", cyc, MINP + 27*PSTEP);
    chk("col_first_map", inv_array, exp_map);
    repeat (MINP + 27*PSTEP - 1) @(negedge clk);
    bvalid = 1'b1; bx = 5'd1; by = 4'd1;
    @(negedge clk); bvalid = 1'b0;
    exp_map[1] = 1'b0;
    chk("col_hit", hit, 1'b1);
    chk("col_alive", alive, 6'd26);
    chk("col_no_step_yet", inv_array, exp_map);
    @(negedge clk);
    model_step();
    chk("col_late_step", inv_array, exp_map);
    wait_change(cyc);
    model_step();
    chk("col_gap26", cyc, MINP + 26*PSTEP);
    chk("col_map2", inv_array, exp_map);

    // kill the whole wave
    do_start();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < 9; c++) shoot(5'(c), 4'(r + 1));
    @(negedge clk); bvalid = 1'b0;
    chk("clr_last_hit", {hit, hit_row, hit_col}, {1'b1, 2'd2, 5'd8});
    chk("clr_flag", cleared, 1'b1);
    chk("clr_alive", alive, 6'd0);
    chk("clr_array", inv_array, 60'h0);
`ifdef INVADER_GRID_SCORE_EN
    chk("score_clear", score, 16'd540);
`endif
    repeat (200) @(negedge clk);
    chk("clr_hold", {inv_array, inv_row, cleared, hit}, {60'h0, 4'd0, 1'b1, 1'b0});
    do_start();
    chk("restart_array", inv_array, FULL_MAP);
    chk("restart_flags", {cleared, landed, alive}, {1'b0, 1'b0, 6'd27});
`ifdef INVADER_GRID_SCORE_EN
    chk("score_restart", score, 16'd0);
`endif

    // full march to landing, every step checked
    do_start();
    for (int s = 0; s < 168 && exp_row != 4'd14; s++) begin
      wait_change(cyc);
      model_step();
      chk($sformatf("march%0d_gap", s), cyc, MINP + 27*PSTEP);
      chk($sformatf("march%0d_map", s), inv_array, exp_map);
      chk($sformatf("march%0d_row", s), inv_row, exp_row);
      chk($sformatf("march%0d_landed", s), landed, (exp_row == 4'd14));
    end
    chk("land_row", inv_row, 4'd14);
    chk("land_flag", landed, 1'b1);
    col0 = 0;
    for (int c = COLS - 1; c >= 0; c--) if (exp_map[c]) col0 = c;
    shoot(5'(col0), 4'd15);
    @(negedge clk); bvalid = 1'b0;
    chk("land_no_hit", hit, 1'b0);
    chk("land_alive", alive, 6'd27);
    repeat (200) @(negedge clk);
    chk("land_frozen", {inv_array, inv_row, landed}, {exp_map, 4'd14, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
